// File: rtl/carregador_programa.sv
// Program loader: framed byte stream (A5, N, N big-endian words, optional XOR checksum) into instruction ROM.
// Latency: ROM write strobe in the cycle after the low byte is accepted; status updates in the cycle after the last byte.
// Backpressure: byte_ready is low only during the one-cycle WRITE bubble per word; optional checksum via LOADER_CHECKSUM_EN.
module carregador_programa #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              rom_wr_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [7:0]        words_loaded
);

  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, COUNT, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t     state;
  logic [7:0] count_n;
  logic [7:0] word_idx;
  logic [7:0] hi_byte;
  logic       accept;
  logic       last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  // Ready is decoded from state: the only stall is the WRITE bubble.
  assign byte_ready   = (state != WRITE);
  assign accept       = byte_valid && byte_ready;
  // 9-bit compare so N == 255 terminates without wrapping the index.
  assign last_word    = ({1'b0, word_idx} + 9'd1) == {1'b0, count_n};
  assign words_loaded = word_idx;

  // Frame parser, word assembly, ROM write strobe and load status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count_n    <= 8'd0;
      word_idx   <= 8'd0;
      hi_byte    <= 8'd0;
      rom_wr_en  <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      rom_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && byte_data == HDR) begin
            state <= COUNT;
`ifdef LOADER_CHECKSUM_EN
            csum  <= 8'd0;
`endif
          end
        end
        COUNT: begin
          if (accept) begin
            count_n <= byte_data;
            if (byte_data == 8'd0) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else begin
              word_idx <= 8'd0;
              state    <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_byte <= byte_data;
`ifdef LOADER_CHECKSUM_EN
            csum    <= csum ^ byte_data;
`endif
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            rom_wr_en <= 1'b1;
            rom_addr  <= ADDR_W'(word_idx);
            rom_wdata <= {hi_byte, byte_data};
`ifdef LOADER_CHECKSUM_EN
            csum      <= csum ^ byte_data;
`endif
            state     <= WRITE;
          end
        end
        WRITE: begin
          word_idx <= word_idx + 8'd1;
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state     <= DONE;
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
`endif
          end else begin
            state <= DATA_HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (byte_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end
`endif
        DONE, ERROR: begin
          // Only a new header restarts; everything else is dropped.
          if (accept && byte_data == HDR) begin
            state      <= COUNT;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Program loader for the 16-bit processor's instruction ROM: the writer at the other end of the fetch stage's read-only ROM port. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit words. Each word is written to consecutive ROM addresses from 0, and the checksum is optionally verified. The processor is held in reset (`cpu_hold`) until a complete, valid program has been loaded.

## Interface
- `ADDR_W`, 8: ROM address width; must be ≥ 8.
- `DATA_W`, 16: instruction word width; fixed at 16 (two bytes per word).

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `byte_valid` in 1: source has a byte on `byte_data`.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte. A transfer occurs on a rising edge with `byte_valid && byte_ready`.
- `rom_wr_en` out 1: one-cycle ROM write strobe.
- `rom_addr` out ADDR_W: ROM write address.
- `rom_wdata` out DATA_W: ROM write data.
- `cpu_hold` out 1: holds IF/Controle in reset while 1.
- `load_done` out 1: last frame was loaded successfully.
- `load_error` out 1: last frame was rejected.
- `words_loaded` out 8: words written in the current or last frame.

## Operation
- Frame format: `0xA5` header, count byte N (1..255), N words sent high byte then low byte, then a checksum byte (see Configuration).
- FSM states: IDLE, COUNT, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
  - IDLE: wait for a header byte. Bytes other than `0xA5` are accepted and discarded.
  - COUNT: latch N.
    - N == 0 → ERROR.
    - Otherwise clear the word index and `words_loaded`; go to DATA_HI.
  - DATA_HI: latch the high byte → DATA_LO.
  - DATA_LO: latch the low byte → WRITE.
  - WRITE: assert `rom_wr_en` for exactly one cycle with `rom_addr` = word index and `rom_wdata` = {hi, lo}. Increment the index and `words_loaded`.
    - If the index reaches N → CHECK (or DONE when checksum is compiled out).
    - Otherwise → DATA_HI.
  - CHECK: compare the received byte with the running XOR of all 2N data bytes.
    - Equal → DONE.
    - Not equal → ERROR.
  - DONE: `load_done`=1, `cpu_hold`=0.
  - ERROR: `load_error`=1, `cpu_hold`=1.
- In DONE or ERROR, a received `0xA5` restarts the load: → COUNT, `cpu_hold`=1, `load_done` and `load_error` cleared. Any other byte is discarded.
- The running XOR is cleared on header acceptance. Header, count and checksum bytes are not included in it.
- Words already written before an ERROR are not rolled back.
- `byte_ready` = 0 only in WRITE; it is 1 in every other state.

## Timing
- Reset values:
  - State IDLE.
  - `byte_ready`=1, `rom_wr_en`=0, `rom_addr`=0, `rom_wdata`=0.
  - `cpu_hold`=1, `load_done`=0, `load_error`=0, `words_loaded`=0.
- All outputs except `byte_ready` are registered. `byte_ready` is decoded from state.
- The low byte is accepted at edge k. `rom_wr_en`, `rom_addr` and `rom_wdata` are valid in cycle k..k+1. The next byte can be accepted at edge k+2 at the earliest.
- Maximum throughput: one byte per cycle, except one bubble per word.
- The checksum byte is accepted at edge c. `load_done`/`load_error` and `cpu_hold` change after edge c and are visible in cycle c..c+1.
- `reset_n` asserted mid-frame: all state and outputs return to reset values immediately. Any in-flight write strobe is dropped.
- `byte_valid` may stay high indefinitely. No byte may be lost or duplicated across the WRITE bubble.

## Configuration
- `LOADER_CHECKSUM_EN`:
  - Defined: the CHECK state exists and the frame ends with the XOR checksum byte.
  - Undefined: no checksum byte is expected, and WRITE of the last word goes directly to DONE. ERROR is then reachable only via N == 0.

## Test plan
- Load with `LOADER_CHECKSUM_EN`: stream A5,03,12,34,AB,CD,00,01,41 → writes 0x1234@0, 0xABCD@1, 0x0001@2, one strobe each. Then `load_done`=1, `cpu_hold`=0, `words_loaded`=3.
- Bad checksum: same frame ending in 0x40 → three writes still occur; `load_error`=1, `load_done`=0, `cpu_hold`=1.
- Zero count: stream A5,00 → ERROR with no writes. A following valid frame (A5,01,BE,EF,51) recovers: write 0xBEEF@0, `load_done`=1.
- Leading garbage: 00,FF,5A before A5,01,00,07,07 → the garbage bytes are discarded and a single write of 0x0007@0 occurs.
- Reset mid-load: assert `reset_n`=0 after the second word of a 3-word frame → all outputs at reset values, `cpu_hold`=1. A full reload afterwards succeeds.
- Back-pressure: `byte_valid` held at 1 with a byte queue → `byte_ready` drops for exactly one cycle per word. All bytes are consumed in order with correct addresses and data.
